// File: rtl/rgb_luma_pkg.sv
// Shared types and constants for the RGB-to-luma pipeline.
package rgb_luma_pkg;

  localparam int unsigned COEF_FRAC = 10;
  localparam int unsigned COEF_W    = COEF_FRAC + 1;

  typedef enum logic [1:0] {
    LUMA_601  = 2'd0,
    LUMA_709  = 2'd1,
    LUMA_AVG  = 2'd2,
    LUMA_RSVD = 2'd3
  } luma_mode_e;

  // Q0.10 coefficients; each set sums to 1024
  localparam logic [COEF_W-1:0] COEF_601_R = 11'd306;
  localparam logic [COEF_W-1:0] COEF_601_G = 11'd601;
  localparam logic [COEF_W-1:0] COEF_601_B = 11'd117;
  localparam logic [COEF_W-1:0] COEF_709_R = 11'd218;
  localparam logic [COEF_W-1:0] COEF_709_G = 11'd732;
  localparam logic [COEF_W-1:0] COEF_709_B = 11'd74;
  localparam logic [COEF_W-1:0] COEF_AVG_R = 11'd341;
  localparam logic [COEF_W-1:0] COEF_AVG_G = 11'd342;
  localparam logic [COEF_W-1:0] COEF_AVG_B = 11'd341;

  typedef struct packed {
    logic [COEF_W-1:0] r;
    logic [COEF_W-1:0] g;
    logic [COEF_W-1:0] b;
  } luma_coef_t;

  // Control payload carried alongside the pixel data in every stage
  typedef struct packed {
    logic vld;
    logic sof;
  } stage_tag_t;

endpackage

// File: rtl/rgb_luma_coef.sv
// Combinational conversion-mode to coefficient-set lookup.
module rgb_luma_coef
  import rgb_luma_pkg::*;
(
  input  luma_mode_e mode_i,
  output luma_coef_t coef_o
);

  // Reserved mode falls back to BT.601
  always_comb begin
    coef_o = '{r: COEF_601_R, g: COEF_601_G, b: COEF_601_B};
    case (mode_i)
      LUMA_709: coef_o = '{r: COEF_709_R, g: COEF_709_G, b: COEF_709_B};
      LUMA_AVG: coef_o = '{r: COEF_AVG_R, g: COEF_AVG_G, b: COEF_AVG_B};
      default:  coef_o = '{r: COEF_601_R, g: COEF_601_G, b: COEF_601_B};
    endcase
  end

endmodule

// File: rtl/rgb_luma_pipe.sv
// Three-stage RGB-to-luma pipeline with threshold mask, line/frame
// markers and per-frame foreground pixel count.
module rgb_luma_pipe
  import rgb_luma_pkg::*;
#(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned LINE_W  = 640,
  parameter int unsigned FRAME_H = 480,
  parameter int unsigned CNT_W   = 20
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  input  logic             in_sof,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_y,
  output logic             out_mask,
  output logic             out_eol,
  output logic             out_eof,
  output logic [CNT_W-1:0] fg_count,
  output logic             fg_valid
);

  localparam int unsigned PROD_W = PIX_W + COEF_W;
  localparam int unsigned SUM_W  = PIX_W + 12;
  localparam int unsigned PX_W   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned LN_W   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [PX_W-1:0]  PX_LAST = PX_W'(LINE_W - 1);
  localparam logic [LN_W-1:0]  LN_LAST = LN_W'(FRAME_H - 1);
  localparam logic [SUM_W-1:0] ROUND   = SUM_W'(1) << (COEF_FRAC - 1);

  luma_coef_t coef;

  stage_tag_t              tag1_q, tag2_q, tag3_q;
  logic [PROD_W-1:0]       p_r_q, p_g_q, p_b_q;
  logic [PIX_W-1:0]        thr1_q, thr2_q;
  logic [PIX_W-1:0]        y2_q, y3_q;
  logic                    mask3_q;
  logic                    ld1, ld2, ld3;

  logic [SUM_W-1:0]        sum_d, y_full;
  logic [PIX_W-1:0]        y_d;

  logic [PX_W-1:0]         px_q, px_d, px_eff;
  logic [LN_W-1:0]         ln_q, ln_d, ln_eff;
  logic [CNT_W-1:0]        acc_q, acc_d, acc_base, acc_inc;
  logic [CNT_W-1:0]        fg_count_q, fg_count_d;
  logic                    fg_valid_q, fg_valid_d;
  logic                    eol, eof, xfer;

  rgb_luma_coef u_coef (
    .mode_i (luma_mode_e'(mode)),
    .coef_o (coef)
  );

  // A stage loads when empty or when its content moves on this cycle
  always_comb begin
    ld3 = ~tag3_q.vld | out_ready;
    ld2 = ~tag2_q.vld | ld3;
    ld1 = ~tag1_q.vld | ld2;
  end

  assign in_ready  = ld1;
  assign out_valid = tag3_q.vld;

  // S1: per-channel products with the coefficient set of this pixel's mode
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag1_q <= '0;
      p_r_q  <= '0;
      p_g_q  <= '0;
      p_b_q  <= '0;
      thr1_q <= '0;
    end else if (ld1) begin
      tag1_q <= '{vld: in_valid, sof: in_sof};
      p_r_q  <= PROD_W'(in_r) * PROD_W'(coef.r);
      p_g_q  <= PROD_W'(in_g) * PROD_W'(coef.g);
      p_b_q  <= PROD_W'(in_b) * PROD_W'(coef.b);
      thr1_q <= thresh;
    end
  end

  // Rounded, scaled and saturated luma from the S1 products
  always_comb begin
    sum_d  = SUM_W'(p_r_q) + SUM_W'(p_g_q) + SUM_W'(p_b_q) + ROUND;
    y_full = sum_d >> COEF_FRAC;
    y_d    = (|y_full[SUM_W-1:PIX_W]) ? '1 : y_full[PIX_W-1:0];
  end

  // S2: luma register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag2_q <= '0;
      y2_q   <= '0;
      thr2_q <= '0;
    end else if (ld2) begin
      tag2_q <= tag1_q;
      y2_q   <= y_d;
      thr2_q <= thr1_q;
    end
  end

  // S3: threshold compare and output register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag3_q  <= '0;
      y3_q    <= '0;
      mask3_q <= 1'b0;
    end else if (ld3) begin
      tag3_q  <= tag2_q;
      y3_q    <= y2_q;
      mask3_q <= (y2_q >= thr2_q);
    end
  end

  assign out_y    = y3_q;
  assign out_mask = mask3_q;

  // Position and foreground bookkeeping for the pixel currently in S3.
  // An sof pixel overrides the stored position and accumulator so that
  // markers and counts resynchronise on that very pixel.
  always_comb begin
    xfer     = tag3_q.vld & out_ready;
    px_eff   = tag3_q.sof ? '0 : px_q;
    ln_eff   = tag3_q.sof ? '0 : ln_q;
    eol      = (px_eff == PX_LAST);
    eof      = eol & (ln_eff == LN_LAST);
    acc_base = tag3_q.sof ? '0 : acc_q;
    acc_inc  = (mask3_q && (acc_base != '1)) ? acc_base + CNT_W'(1) : acc_base;

    px_d       = px_q;
    ln_d       = ln_q;
    acc_d      = acc_q;
    fg_count_d = fg_count_q;
    fg_valid_d = 1'b0;
    if (xfer) begin
      if (eol) begin
        px_d = '0;
        ln_d = (ln_eff == LN_LAST) ? '0 : ln_eff + LN_W'(1);
      end else begin
        px_d = px_eff + PX_W'(1);
        ln_d = ln_eff;
      end
      if (eof) begin
        fg_count_d = acc_inc;
        fg_valid_d = 1'b1;
        acc_d      = '0;
      end else begin
        acc_d = acc_inc;
      end
    end
  end

  assign out_eol = tag3_q.vld & eol;
  assign out_eof = tag3_q.vld & eof;

  // Output-side counters, accumulator and frame statistics
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      px_q       <= '0;
      ln_q       <= '0;
      acc_q      <= '0;
      fg_count_q <= '0;
      fg_valid_q <= 1'b0;
    end else begin
      px_q       <= px_d;
      ln_q       <= ln_d;
      acc_q      <= acc_d;
      fg_count_q <= fg_count_d;
      fg_valid_q <= fg_valid_d;
    end
  end

  assign fg_count = fg_count_q;
  assign fg_valid = fg_valid_q;

endmodule

// File: tb/tb_rgb_luma_pipe.sv
// Directed bench for rgb_luma_pipe with a small line/frame geometry.
module tb_rgb_luma_pipe;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned LINE_W  = 4;
  localparam int unsigned FRAME_H = 2;
  localparam int unsigned CNT_W   = 20;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic             in_sof = 1'b0;
  logic [1:0]       mode = '0;
  logic [PIX_W-1:0] thresh = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PIX_W-1:0] out_y;
  logic             out_mask, out_eol, out_eof;
  logic [CNT_W-1:0] fg_count;
  logic             fg_valid;

  always #5 Clk = ~Clk;

  rgb_luma_pipe #(
    .PIX_W   (PIX_W),
    .LINE_W  (LINE_W),
    .FRAME_H (FRAME_H),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .in_sof    (in_sof),
    .mode      (mode),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_mask  (out_mask),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .fg_count  (fg_count),
    .fg_valid  (fg_valid)
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] r, g, b, thr;
    logic       sof;
    logic [7:0] exp_y;
    logic       exp_mask, exp_eol, exp_eof;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       mask, eol, eof;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  int   fg_pulses = 0;
  logic [CNT_W-1:0] fg_last = '0;
  obs_t mon_q[$];
  vec_t tbl[12];
  vec_t stim[16];
  bit   full_seen;

  function automatic vec_t mk(input logic [1:0] m, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic [7:0] thr, input logic sof,
                              input logic [7:0] y, input logic mask, input logic eol,
                              input logic eof);
    vec_t v;
    v.mode = m; v.r = r; v.g = g; v.b = b; v.thr = thr; v.sof = sof;
    v.exp_y = y; v.exp_mask = mask; v.exp_eol = eol; v.exp_eof = eof;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: records transfers, checks hold-while-stalled, logs fg pulses
  logic       stall_prev = 1'b0;
  logic [7:0] y_prev;
  logic [2:0] fl_prev;
  always @(negedge Clk) begin
    if (out_valid === 1'b1 && stall_prev) begin
      chk("hold_y", out_y, y_prev);
      chk("hold_flags", {out_mask, out_eol, out_eof}, fl_prev);
    end
    stall_prev = (out_valid === 1'b1) && !out_ready;
    y_prev     = out_y;
    fl_prev    = {out_mask, out_eol, out_eof};
    if (out_valid === 1'b1 && out_ready)
      mon_q.push_back('{y: out_y, mask: out_mask, eol: out_eol, eof: out_eof});
    if (fg_valid === 1'b1) begin
      fg_pulses++;
      fg_last = fg_count;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_fg_valid"}, fg_valid, 0);
    chk({tag, "_fg_count"}, fg_count, 0);
    chk({tag, "_out_y"}, out_y, 0);
    chk({tag, "_out_mask"}, out_mask, 0);
    chk({tag, "_out_eol"}, out_eol, 0);
    chk({tag, "_out_eof"}, out_eof, 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    mon_q.delete();
    fg_pulses = 0;
  endtask

  // Streams stim[0..n-1] with out_ready low during cycles lo..hi
  task automatic run_stream(input string tag, input int n, input int lo, input int hi,
                            input bit frame);
    int k = 0;
    int cyc = 0;
    bit acc;
    mon_q.delete();
    full_seen = 1'b0;
    while ((k < n || mon_q.size() < n) && cyc < 300) begin
      out_ready = !(cyc >= lo && cyc <= hi);
      if (k < n) begin
        in_valid = 1'b1;
        mode = stim[k].mode; in_r = stim[k].r; in_g = stim[k].g; in_b = stim[k].b;
        thresh = stim[k].thr; in_sof = stim[k].sof;
      end else begin
        in_valid = 1'b0;
        in_sof = 1'b0;
      end
      @(negedge Clk);
      acc = in_valid && in_ready;
      if (k < n && !in_ready) full_seen = 1'b1;
      tick();
      if (acc) begin
        k++;
        mode = ~mode;
        thresh = ~thresh;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk({tag, "_count"}, mon_q.size(), n);
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      chk($sformatf("%s%0d_y", tag, i), mon_q[i].y, stim[i].exp_y);
      chk($sformatf("%s%0d_mask", tag, i), mon_q[i].mask, stim[i].exp_mask);
      if (frame) begin
        chk($sformatf("%s%0d_eol", tag, i), mon_q[i].eol, stim[i].exp_eol);
        chk($sformatf("%s%0d_eof", tag, i), mon_q[i].eof, stim[i].exp_eof);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            mode  R    G    B    thr  sof  y    mask
    tbl[0]  = mk(2'd0, 255, 255, 255, 128, 0, 255, 1, 0, 0);
    tbl[1]  = mk(2'd0, 255,   0,   0,  80, 0,  76, 0, 0, 0);
    tbl[2]  = mk(2'd1, 255,   0,   0,  50, 0,  54, 1, 0, 0);
    tbl[3]  = mk(2'd2, 255,   0,   0,  85, 0,  85, 1, 0, 0);
    tbl[4]  = mk(2'd3, 255,   0,   0,  77, 0,  76, 0, 0, 0);
    tbl[5]  = mk(2'd0,   0, 255,   0, 150, 0, 150, 1, 0, 0);
    tbl[6]  = mk(2'd0,   0,   0, 255,  30, 0,  29, 0, 0, 0);
    tbl[7]  = mk(2'd0,   0,   0,   0,   0, 0,   0, 1, 0, 0);
    tbl[8]  = mk(2'd1,  10,  20,  30,  20, 0,  19, 0, 0, 0);
    tbl[9]  = mk(2'd0, 100, 150, 200, 141, 0, 141, 1, 0, 0);
    tbl[10] = mk(2'd2,   0, 255,   0, 255, 0,  85, 0, 0, 0);
    tbl[11] = mk(2'd1,   0, 255,   0, 182, 0, 182, 1, 0, 0);

    #3;
    do_reset("rst0");

    // Single pixels: exact 3-cycle latency and per-mode luma values
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; mode = tbl[i].mode; thresh = tbl[i].thr;
      in_r = tbl[i].r; in_g = tbl[i].g; in_b = tbl[i].b; in_sof = 1'b0;
      @(negedge Clk);
      chk("tbl_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0; mode = 2'd2; thresh = '1; in_r = '1; in_g = '1; in_b = '1;
      @(negedge Clk);
      chk("tbl_lat1", out_valid, 0);
      tick();
      @(negedge Clk);
      chk("tbl_lat2", out_valid, 0);
      tick();
      @(negedge Clk);
      chk("tbl_lat3", out_valid, 1);
      chk($sformatf("tbl%0d_y", i), out_y, tbl[i].exp_y);
      chk($sformatf("tbl%0d_mask", i), out_mask, tbl[i].exp_mask);
      tick();
    end

    // Mode changes every pixel, gray 127/128 around thresh 128
    for (int i = 0; i < 8; i++)
      stim[i] = (i % 2 == 0) ? mk(2'(i % 4), 127, 127, 127, 128, 0, 127, 0, 0, 0)
                             : mk(2'(i % 4), 128, 128, 128, 128, 0, 128, 1, 0, 0);
    run_stream("gray", 8, -1, -1, 1'b0);

    // Per-pixel mode and threshold on saturated red
    stim[0] = mk(2'd0, 255, 0, 0, 77, 0, 76, 0, 0, 0);
    stim[1] = mk(2'd1, 255, 0, 0, 54, 0, 54, 1, 0, 0);
    stim[2] = mk(2'd2, 255, 0, 0, 86, 0, 85, 0, 0, 0);
    stim[3] = mk(2'd3, 255, 0, 0, 76, 0, 76, 1, 0, 0);
    run_stream("red", 4, -1, -1, 1'b0);

    // 10 back-to-back pixels, out_ready low in cycles 4..7
    for (int i = 0; i < 10; i++) begin
      logic [7:0] g;
      g = 8'((i + 1) * 10);
      stim[i] = mk(2'(i % 4), g, g, g, 50, 0, g, (i >= 4), 0, 0);
    end
    run_stream("bp", 10, 4, 7, 1'b0);
    chk("bp_in_ready_low", full_seen, 1);

    // One full 4x2 frame, 3 foreground pixels
    do_reset("rst1");
    stim[0] = mk(2'd0,  10,  10,  10, 100, 0,  10, 0, 0, 0);
    stim[1] = mk(2'd0, 200, 200, 200, 100, 0, 200, 1, 0, 0);
    stim[2] = mk(2'd0,  20,  20,  20, 100, 0,  20, 0, 0, 0);
    stim[3] = mk(2'd0,  30,  30,  30, 100, 0,  30, 0, 1, 0);
    stim[4] = mk(2'd0, 150, 150, 150, 100, 0, 150, 1, 0, 0);
    stim[5] = mk(2'd0,  40,  40,  40, 100, 0,  40, 0, 0, 0);
    stim[6] = mk(2'd0,  50,  50,  50, 100, 0,  50, 0, 0, 0);
    stim[7] = mk(2'd0, 250, 250, 250, 100, 0, 250, 1, 1, 1);
    run_stream("fr", 8, -1, -1, 1'b1);
    chk("fr_fg_pulses", fg_pulses, 1);
    chk("fr_fg_last", fg_last, 3);
    chk("fr_fg_count", fg_count, 3);

    // Reset with pixels in flight, then sof in mid-frame
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; mode = 2'd0; thresh = 8'd0; in_sof = 1'b0;
      in_r = 8'd200; in_g = 8'd200; in_b = 8'd200;
      @(negedge Clk);
      chk("pre_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    do_reset("rst2");
    out_ready = 1'b1;
    repeat (5) tick();
    chk("no_stale", mon_q.size(), 0);
    chk("no_stale_pulse", fg_pulses, 0);

    stim[0] = mk(2'd0, 200, 200, 200, 100, 0, 200, 1, 0, 0);
    stim[1] = mk(2'd0, 200, 200, 200, 100, 0, 200, 1, 0, 0);
    stim[2] = mk(2'd0, 200, 200, 200, 100, 1, 200, 1, 0, 0);
    stim[3] = mk(2'd0,  10,  10,  10, 100, 0,  10, 0, 0, 0);
    stim[4] = mk(2'd0,  10,  10,  10, 100, 0,  10, 0, 0, 0);
    stim[5] = mk(2'd0, 200, 200, 200, 100, 0, 200, 1, 1, 0);
    stim[6] = mk(2'd0,  10,  10,  10, 100, 0,  10, 0, 0, 0);
    stim[7] = mk(2'd0,  10,  10,  10, 100, 0,  10, 0, 0, 0);
    stim[8] = mk(2'd0, 200, 200, 200, 100, 0, 200, 1, 0, 0);
    stim[9] = mk(2'd0,  10,  10,  10, 100, 0,  10, 0, 1, 1);
    run_stream("sof", 10, -1, -1, 1'b1);
    chk("sof_fg_pulses", fg_pulses, 1);
    chk("sof_fg_last", fg_last, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_luma_pipe.md
RGB_LUMA_PIPE -- requirements
Module: rgb_luma_pipe

Interface
REQ-001 Parameters SHALL be: PIX_W, default 8, channel/luma width; LINE_W, default 640, pixels per line; FRAME_H, default 480, lines per frame; CNT_W, default 20, width of the foreground count.
REQ-002 Ports SHALL be: Clk  in  1  the single clock; Reset_n  in  1  asynchronous, active-low reset.
REQ-003 Input stream ports SHALL be: in_valid in 1; in_ready out 1; in_r, in_g, in_b in PIX_W each; in_sof in 1, first pixel of a frame.
REQ-004 Control ports SHALL be: mode in 2, conversion mode; thresh in PIX_W, mask threshold.
REQ-005 Output stream ports SHALL be: out_valid out 1; out_ready in 1; out_y out PIX_W, luma; out_mask out 1, luma >= threshold; out_eol out 1, last pixel of a line; out_eof out 1, last pixel of a frame.
REQ-006 Statistics ports SHALL be: fg_count out CNT_W, mask-set pixels in the last completed frame; fg_valid out 1, one-cycle pulse on update.

Function
REQ-007 A transfer SHALL occur on each port when valid and ready are both high at a rising Clk edge.
REQ-008 mode and thresh SHALL be sampled with each accepted input pixel and carried with it through the pipeline; a later change SHALL NOT affect pixels already in flight.
REQ-009 Coefficients SHALL be Q0.10 and sum to 1024 in every mode: 0 = BT.601 (306, 601, 117); 1 = BT.709 (218, 732, 74); 2 = average (341, 342, 341); 3 = reserved, treated as mode 0.
REQ-010 Luma SHALL be y = (cR*R + cG*G + cB*B + 512) >> 10, computed at full width (PIX_W+12 bits), saturated to 2^PIX_W-1.
REQ-011 The pipeline SHALL have three register stages: S1 products, S2 rounded sum with saturation, S3 threshold compare and output register.
REQ-012 Latency from input transfer to out_valid SHALL be 3 cycles while out_ready stays high.
REQ-013 Each stage SHALL load when it is empty or its contents are moving downstream in the same cycle; in_ready = S1 empty or S1 advancing; bubbles SHALL collapse.
REQ-014 Throughput SHALL be one pixel per cycle while out_ready is held high.
REQ-015 While out_valid is high and out_ready is low, out_y, out_mask, out_eol and out_eof SHALL stay stable.
REQ-016 Output-side counters: px_cnt in 0..LINE_W-1 and ln_cnt in 0..FRAME_H-1, advanced on each output transfer; px_cnt wraps to 0 after LINE_W-1 and increments ln_cnt; ln_cnt wraps after FRAME_H-1.
REQ-017 out_eol SHALL be high when px_cnt = LINE_W-1; out_eof SHALL be high when out_eol is high and ln_cnt = FRAME_H-1.
REQ-018 in_sof SHALL travel with its pixel; when that pixel is output, the pixel SHALL be treated as px_cnt = 0, ln_cnt = 0, and counting SHALL continue from there (resynchronisation).
REQ-019 A foreground accumulator SHALL add 1 for each output transfer with out_mask = 1, saturating at 2^CNT_W-1.
REQ-020 On the out_eof transfer, fg_count SHALL load the accumulator including that pixel, fg_valid SHALL pulse for 1 cycle, and the accumulator SHALL clear to 0.
REQ-021 When an sof pixel is output, the accumulator SHALL restart at that pixel's contribution with no fg_valid pulse, so any partial frame is discarded.

Reset
REQ-022 Assertion of Reset_n low SHALL immediately clear all stage valids, out_valid, fg_valid, counters, accumulator, fg_count, out_y, out_mask, out_eol and out_eof to 0.
REQ-023 in_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-024 Reset mid-stream SHALL discard in-flight pixels without producing any output transfer.

Structure
REQ-025 Package rgb_luma_pkg SHALL hold the mode enum (LUMA_601, LUMA_709, LUMA_AVG, LUMA_RSVD), the Q0.10 coefficient constants, COEF_FRAC = 10, and the per-stage payload struct.
REQ-026 Submodule rgb_luma_coef SHALL be a combinational mode-to-coefficient lookup, instantiated once.

Verification
REQ-027 Mode 0, R=G=B=255, out_ready held high -> out_y = 255 exactly 3 cycles after input, no overflow.
REQ-028 Mode 0, (R,G,B) = (255,0,0) -> out_y = 76; mode 1 -> 54; mode 2 -> 85; mode 3 -> 76.
REQ-029 Back-to-back stream of 10 pixels, out_ready low for cycles 4-7 -> no loss or duplication, order preserved, in_ready low once all 3 stages are full.
REQ-030 Mode changed every pixel, thresh = 128, with gray inputs 127 and 128 -> each output uses its own mode; mask = 0 for 127 and 1 for 128.
REQ-031 LINE_W = 4, FRAME_H = 2, 8 pixels of which 3 are above threshold -> out_eol on pixels 3 and 7, out_eof on pixel 7, fg_count = 3, fg_valid pulses once.
REQ-032 Reset_n pulsed low with 2 pixels in flight, then in_sof mid-frame -> no stale outputs after reset; counters restart at the sof pixel and no fg_valid pulse occurs for the partial frame.
